ecc_109_err_log: RTL and testbench
==================================

Name: ecc_109_err_log

Overview:
- Downstream companion of the 109-bit ECC decode/fault-detect stage on the FIFO read path.
- Consumes the per-read status outputs of that stage: sbit_err, dbit_err and ecc_fault, qualified by a read-valid strobe.
- Maintains saturating event counters, a monotonic severity state machine, and a first-error capture (read address + type).
- Drives a maskable level interrupt to the control/status register block; all state is cleared by a single-cycle clear pulse.

Parameters:
- ADDR_WIDTH, 8, width of the FIFO read address captured on first error.
- CNT_WIDTH, 16, width of each saturating event counter.

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous, active-high reset.
- rd_vld  input  1  one-cycle qualifier; sbit_err/dbit_err/ecc_fault/rd_addr are valid this cycle.
- rd_addr  input  ADDR_WIDTH  FIFO read address of the qualified word.
- sbit_err  input  1  correctable single-bit error from the decode stage.
- dbit_err  input  1  uncorrectable double-bit error from the decode stage.
- ecc_fault  input  1  decoder self-check mismatch (dual-decoder compare failed).
- err_clr  input  1  pulse; clears counters, severity, first-error capture.
- irq_en  input  3  interrupt enables {fault, dbit, sbit}.
- sbit_cnt  output  CNT_WIDTH  number of qualified sbit_err events.
- dbit_cnt  output  CNT_WIDTH  number of qualified dbit_err events.
- fault_cnt  output  CNT_WIDTH  number of qualified ecc_fault events.
- health  output  2  severity state: 0 CLEAN, 1 SBIT, 2 DBIT, 3 FAULT.
- first_err_vld  output  1  first-error capture holds valid data.
- first_err_addr  output  ADDR_WIDTH  rd_addr of first erroneous read.
- first_err_type  output  2  type of first error, encoded as for health.
- irq  output  1  level interrupt.

Behaviour:
- Reset (rst=1 at a clk edge): all counters 0, health=CLEAN, first_err_vld=0, first_err_addr=0, first_err_type=0, irq=0.
- Inputs are ignored when rd_vld=0. All register updates occur at the clk edge; outputs reflect an event one cycle after its rd_vld cycle.
- Counters:
  - Each counter increments by 1 independently when rd_vld and its input are both 1.
  - Simultaneous sbit_err, dbit_err and ecc_fault each count.
  - Counters saturate at 2^CNT_WIDTH-1 and hold; they never wrap.
- Event type:
  - Priority for a qualified read is ecc_fault > dbit_err > sbit_err.
  - ev_type is 3, 2 or 1 by that priority; ev_type=0 when no error input is set.
- Severity FSM (health):
  - CLEAN->SBIT/DBIT/FAULT; SBIT->DBIT/FAULT; DBIT->FAULT.
  - Next state = max(current, ev_type). The state never decreases except via err_clr or rst.
  - FAULT is absorbing until cleared.
- First-error capture:
  - On a qualified read with ev_type!=0 while first_err_vld=0: latch rd_addr and ev_type, and set first_err_vld.
  - Later errors do not overwrite the capture.
- err_clr:
  - Returns all state to reset values at the next edge.
  - If a qualified error occurs in the same cycle as err_clr, clear is applied first, then the event. Result: the matching counter(s) = 1, health=ev_type, and the event is captured as the first error.
  - err_clr held high for several cycles clears on every cycle.
- rst has priority over err_clr and over events. Reset asserted mid-stream discards that cycle's event.
- irq:
  - Combinational: irq = (irq_en[0] & health>=SBIT) | (irq_en[1] & health>=DBIT) | (irq_en[2] & health==FAULT).
  - irq therefore follows irq_en changes immediately and is glitch-free with respect to registered state.
- The block is purely observational and never back-pressures the read path.

Decomposition:
- Shared package ecc_log_pkg:
  - 2-bit severity/type constants ST_CLEAN=0, ST_SBIT=1, ST_DBIT=2, ST_FAULT=3.
  - Index constants for the irq_en bits.
- One sub-module ecc_sat_cnt (parameter CNT_WIDTH; ports clk, rst, clr, inc, cnt), instantiated three times.
- FSM, capture and irq logic live in the top.

Test Plan:
- rst, then three qualified reads with sbit_err=1 -> sbit_cnt=3, health=1, first_err_type=1, first_err_addr = first read's rd_addr; irq=1 only when irq_en[0]=1.
- sbit read at addr 0x10, then dbit read at 0x22, then ecc_fault read at 0x30 -> health 1,2,3 on successive cycles; first_err_addr=0x10, first_err_type=1; irq_en=3'b100 gives irq=1 only after the fault.
- sbit_err=dbit_err=ecc_fault=1 with rd_vld=0 -> no change; the same inputs with rd_vld=1 -> all three counters = 1, health=3, first_err_type=3.
- CNT_WIDTH=4, 20 qualified dbit reads -> dbit_cnt holds 15 from the 15th read onward, no wrap.
- health=3 with counts nonzero; err_clr together with a qualified sbit read at addr 0x05 -> next cycle sbit_cnt=1, dbit_cnt=0, fault_cnt=0, health=1, first_err_addr=0x05, first_err_type=1.
- Mid-stream rst asserted in the same cycle as a qualified dbit read -> all outputs 0 next cycle; irq=0 regardless of irq_en.

Source files
------------

// File: rtl/ecc_log_pkg.sv
// Shared severity/type encoding and interrupt-enable bit positions for the
// ECC error logger.
package ecc_log_pkg;

  localparam logic [1:0] ST_CLEAN = 2'd0;
  localparam logic [1:0] ST_SBIT  = 2'd1;
  localparam logic [1:0] ST_DBIT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int IRQ_SBIT  = 0;
  localparam int IRQ_DBIT  = 1;
  localparam int IRQ_FAULT = 2;

  // Highest-severity error reported on a read; ST_CLEAN when none is set.
  function automatic logic [1:0] ev_type(input logic sbit, input logic dbit, input logic fault);
    if (fault) begin
      return ST_FAULT;
    end else if (dbit) begin
      return ST_DBIT;
    end else if (sbit) begin
      return ST_SBIT;
    end else begin
      return ST_CLEAN;
    end
  endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter. A clear that coincides with an increment
// restarts the count at one, so the event is not lost.
module ecc_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_r;

  // Count register: reset, clear-then-count, saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (clr) begin
      cnt_r <= inc ? CNT_ONE : {CNT_WIDTH{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ecc_109_err_log.sv
// Error logger behind the 109-bit ECC decode stage: event counters, monotonic
// severity state, first-error capture and a maskable level interrupt.
module ecc_109_err_log
  import ecc_log_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic                  err_clr,
  input  logic [2:0]            irq_en,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [1:0]            health,
  output logic                  first_err_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_type,
  output logic                  irq
);

  logic [1:0]            ev_type_s;
  logic [1:0]            health_base_s;
  logic [1:0]            health_nxt_s;
  logic                  fv_base_s;
  logic                  fv_nxt_s;
  logic [ADDR_WIDTH-1:0] fa_base_s;
  logic [ADDR_WIDTH-1:0] fa_nxt_s;
  logic [1:0]            ft_base_s;
  logic [1:0]            ft_nxt_s;

  logic [1:0]            health_r;
  logic                  fv_r;
  logic [ADDR_WIDTH-1:0] fa_r;
  logic [1:0]            ft_r;

  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
    .clk(clk), .rst(rst), .clr(err_clr), .inc(rd_vld & sbit_err), .cnt(sbit_cnt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
    .clk(clk), .rst(rst), .clr(err_clr), .inc(rd_vld & dbit_err), .cnt(dbit_cnt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
    .clk(clk), .rst(rst), .clr(err_clr), .inc(rd_vld & ecc_fault), .cnt(fault_cnt)
  );

  // Next-state logic: clear is folded into the base value before the event is applied.
  always_comb begin
    ev_type_s     = ev_type(sbit_err, dbit_err, ecc_fault);
    health_base_s = err_clr ? ST_CLEAN : health_r;
    fv_base_s     = err_clr ? 1'b0 : fv_r;
    fa_base_s     = err_clr ? {ADDR_WIDTH{1'b0}} : fa_r;
    ft_base_s     = err_clr ? ST_CLEAN : ft_r;

    if (rd_vld && (ev_type_s > health_base_s)) begin
      health_nxt_s = ev_type_s;
    end else begin
      health_nxt_s = health_base_s;
    end

    if (rd_vld && (ev_type_s != ST_CLEAN) && !fv_base_s) begin
      fv_nxt_s = 1'b1;
      fa_nxt_s = rd_addr;
      ft_nxt_s = ev_type_s;
    end else begin
      fv_nxt_s = fv_base_s;
      fa_nxt_s = fa_base_s;
      ft_nxt_s = ft_base_s;
    end
  end

  // Severity and first-error capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      health_r <= ST_CLEAN;
      fv_r     <= 1'b0;
      fa_r     <= {ADDR_WIDTH{1'b0}};
      ft_r     <= ST_CLEAN;
    end else begin
      health_r <= health_nxt_s;
      fv_r     <= fv_nxt_s;
      fa_r     <= fa_nxt_s;
      ft_r     <= ft_nxt_s;
    end
  end

  assign health         = health_r;
  assign first_err_vld  = fv_r;
  assign first_err_addr = fa_r;
  assign first_err_type = ft_r;

  // Decoded from registered state only, so irq_en changes take effect at once.
  assign irq = (irq_en[IRQ_SBIT]  & (health_r >= ST_SBIT))
             | (irq_en[IRQ_DBIT]  & (health_r >= ST_DBIT))
             | (irq_en[IRQ_FAULT] & (health_r == ST_FAULT));

endmodule

// File: tb/tb_ecc_109_err_log.sv
// Bench for ecc_109_err_log: directed scenarios plus randomized traffic
// against a behavioural model, compared on every falling edge.
module tb_ecc_109_err_log;

  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, rd_vld, sbit_err, dbit_err, ecc_fault, err_clr;
  logic [AW-1:0] rd_addr;
  logic [2:0]    irq_en;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [1:0]    health, first_err_type;
  logic          first_err_vld, irq;
  logic [AW-1:0] first_err_addr;

  ecc_109_err_log #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rd_vld(rd_vld), .rd_addr(rd_addr),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .err_clr(err_clr), .irq_en(irq_en),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .health(health), .first_err_vld(first_err_vld),
    .first_err_addr(first_err_addr), .first_err_type(first_err_type), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_s, m_d, m_f, m_h, m_fv, m_fa, m_ft;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c < CMAX) ? c + 1 : CMAX;
  endfunction

  // Model of one clock edge, computed from the current inputs.
  task automatic model_edge();
    int ev;
    if (rst) begin
      m_s = 0; m_d = 0; m_f = 0; m_h = 0; m_fv = 0; m_fa = 0; m_ft = 0;
    end else begin
      if (err_clr) begin
        m_s = 0; m_d = 0; m_f = 0; m_h = 0; m_fv = 0; m_fa = 0; m_ft = 0;
      end
      if (rd_vld) begin
        if (sbit_err)  m_s = sat_inc(m_s);
        if (dbit_err)  m_d = sat_inc(m_d);
        if (ecc_fault) m_f = sat_inc(m_f);
        ev = ecc_fault ? 3 : dbit_err ? 2 : sbit_err ? 1 : 0;
        if (ev > m_h) m_h = ev;
        if (ev != 0 && m_fv == 0) begin
          m_fv = 1; m_fa = int'(rd_addr); m_ft = ev;
        end
      end
    end
  endtask

  function automatic int model_irq();
    return ((irq_en[0] && m_h >= 1) || (irq_en[1] && m_h >= 2) ||
            (irq_en[2] && m_h == 3)) ? 1 : 0;
  endfunction

  task automatic compare_all();
    chk("sbit_cnt", sbit_cnt, m_s);
    chk("dbit_cnt", dbit_cnt, m_d);
    chk("fault_cnt", fault_cnt, m_f);
    chk("health", health, m_h);
    chk("first_err_vld", first_err_vld, m_fv);
    chk("first_err_addr", first_err_addr, m_fa);
    chk("first_err_type", first_err_type, m_ft);
    chk("irq", irq, model_irq());
  endtask

  task automatic step(input bit v, input logic [AW-1:0] a, input bit s, input bit d,
                      input bit f, input bit c, input bit r);
    rd_vld = v; rd_addr = a; sbit_err = s; dbit_err = d; ecc_fault = f;
    err_clr = c; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; rd_vld = 1'b0; rd_addr = 8'h00; sbit_err = 1'b0; dbit_err = 1'b0;
    ecc_fault = 1'b0; err_clr = 1'b0; irq_en = 3'b111;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("reset_health", health, 2'd0);
    chk("reset_irq", irq, 1'b0);

    // Three sbit reads.
    irq_en = 3'b001;
    step(1, 8'h41, 1, 0, 0, 0, 0);
    step(1, 8'h42, 1, 0, 0, 0, 0);
    step(1, 8'h43, 1, 0, 0, 0, 0);
    chk("t1_sbit_cnt", sbit_cnt, 4'd3);
    chk("t1_health", health, 2'd1);
    chk("t1_first_type", first_err_type, 2'd1);
    chk("t1_first_addr", first_err_addr, 8'h41);
    chk("t1_irq_en0", irq, 1'b1);
    irq_en = 3'b110;
    #1;
    chk("t1_irq_masked", irq, 1'b0);

    // Escalation sbit -> dbit -> fault.
    irq_en = 3'b100;
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(1, 8'h10, 1, 0, 0, 0, 0);
    chk("t2_h1", health, 2'd1);
    chk("t2_irq1", irq, 1'b0);
    step(1, 8'h22, 0, 1, 0, 0, 0);
    chk("t2_h2", health, 2'd2);
    chk("t2_irq2", irq, 1'b0);
    step(1, 8'h30, 0, 0, 1, 0, 0);
    chk("t2_h3", health, 2'd3);
    chk("t2_irq3", irq, 1'b1);
    chk("t2_first_addr", first_err_addr, 8'h10);
    chk("t2_first_type", first_err_type, 2'd1);

    // All error inputs, unqualified then qualified.
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h77, 1, 1, 1, 0, 0);
    chk("t3_noqual_health", health, 2'd0);
    chk("t3_noqual_sbit", sbit_cnt, 4'd0);
    step(1, 8'h77, 1, 1, 1, 0, 0);
    chk("t3_sbit", sbit_cnt, 4'd1);
    chk("t3_dbit", dbit_cnt, 4'd1);
    chk("t3_fault", fault_cnt, 4'd1);
    chk("t3_health", health, 2'd3);
    chk("t3_first_type", first_err_type, 2'd3);

    // Saturation with a 4-bit counter.
    step(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      step(1, 8'(i), 0, 1, 0, 0, 0);
      chk("t4_dbit_sat", dbit_cnt, (i < 15) ? i : 15);
    end

    // Clear together with an sbit read.
    step(1, 8'h60, 0, 0, 1, 0, 0);
    chk("t5_pre_health", health, 2'd3);
    step(1, 8'h05, 1, 0, 0, 1, 0);
    chk("t5_sbit", sbit_cnt, 4'd1);
    chk("t5_dbit", dbit_cnt, 4'd0);
    chk("t5_fault", fault_cnt, 4'd0);
    chk("t5_health", health, 2'd1);
    chk("t5_first_addr", first_err_addr, 8'h05);
    chk("t5_first_type", first_err_type, 2'd1);

    // Reset coinciding with a dbit read.
    irq_en = 3'b111;
    step(1, 8'h33, 0, 1, 0, 0, 1);
    chk("t6_dbit", dbit_cnt, 4'd0);
    chk("t6_health", health, 2'd0);
    chk("t6_first_vld", first_err_vld, 1'b0);
    chk("t6_irq", irq, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      irq_en = 3'($urandom_range(7, 0));
      step(($urandom_range(3, 0) != 0), 8'($urandom),
           ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(15, 0) == 0), ($urandom_range(63, 0) == 0),
           ($urandom_range(255, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
